mem_port_arbiter: RTL and testbench

- Shares one single-port unified memory between the instruction-fetch side and the data (load/store) side of the CPU.
- Sequences each access as request -> issue -> wait -> done.
- Applies fixed data-first priority with an anti-starvation limit for fetch.
- Sits between the control unit's memory signals and the RAM macro, replacing separate I/D memories.

---
 rtl/mem_port_arbiter_pkg.sv | 21 ++
 rtl/mem_port_arbiter_prio.sv | 69 ++++++
 rtl/mem_port_arbiter.sv | 124 ++++++++++++
 tb/tb_mem_port_arbiter.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the unified-memory port arbiter: FSM states, owner encoding,
// and counter width helper. Optional build macro: MEMARB_RR_EN (see mem_arb_prio).
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_t;

    function automatic int cnt_width(input int limit);
        return $clog2(limit + 1);
    endfunction

endpackage

// File: rtl/mem_port_arbiter_prio.sv
// Winner selection between fetch and data sides. Default: data-first with a
// saturating fetch-starvation counter; MEMARB_RR_EN: alternate winner on ties.
module mem_arb_prio
    import mem_arb_pkg::*;
#(
    parameter int STARVE_LIMIT = 3
) (
    input  logic   clk,
    input  logic   reset_n,
    input  logic   i_arb,
    input  logic   i_ireq,
    input  logic   i_dreq,
    output owner_t o_win
);

`ifdef MEMARB_RR_EN
    // Resets to "data won last" so fetch takes the first tie.
    logic r_last_d;

    always_comb begin
        o_win = OWN_I;
        if (i_ireq && i_dreq) begin
            o_win = r_last_d ? OWN_I : OWN_D;
        end else if (i_dreq) begin
            o_win = OWN_D;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_last_d <= 1'b1;
        end else if (i_arb) begin
            r_last_d <= (o_win == OWN_D);
        end
    end
`else
    localparam int CW = cnt_width(STARVE_LIMIT);

    logic [CW-1:0] r_starve;
    logic          w_tie;
    logic          w_starved;

    assign w_tie     = i_ireq && i_dreq;
    assign w_starved = (r_starve == CW'(STARVE_LIMIT));

    always_comb begin
        o_win = OWN_I;
        if (w_tie) begin
            o_win = w_starved ? OWN_I : OWN_D;
        end else if (i_dreq) begin
            o_win = OWN_D;
        end
    end

    // Only contested arbitrations move the counter; a lone requester leaves it alone.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_starve <= '0;
        end else if (i_arb && w_tie) begin
            if (w_starved) begin
                r_starve <= '0;
            end else begin
                r_starve <= r_starve + CW'(1);
            end
        end
    end
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between fetch and data sides: IDLE->ISSUE->WAIT->DONE.
// Optional build macro MEMARB_RR_EN selects round-robin tie-breaking in mem_arb_prio.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW           = 16,
    parameter int DW           = 16,
    parameter int MEM_LAT      = 1,
    parameter int STARVE_LIMIT = 3
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          i_req,
    input  logic [AW-1:0] i_addr,
    output logic          i_done,
    output logic [DW-1:0] i_rdata,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_done,
    output logic [DW-1:0] d_rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy,
    output logic          owner_d
);

    localparam int LW = cnt_width(MEM_LAT);

    state_t        r_state;
    owner_t        r_owner;
    logic [LW-1:0] r_lat;
    owner_t        w_win;
    logic          w_arb;

    assign w_arb = (r_state == IDLE) && (i_req || d_req);

    mem_arb_prio #(
        .STARVE_LIMIT(STARVE_LIMIT)
    ) u_prio (
        .clk    (clk),
        .reset_n(reset_n),
        .i_arb  (w_arb),
        .i_ireq (i_req),
        .i_dreq (d_req),
        .o_win  (w_win)
    );

    // mem_addr/mem_wdata double as the transaction latches; mem_we is the
    // latched write flag during ISSUE, so no separate copies are kept.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= IDLE;
            r_owner   <= OWN_I;
            r_lat     <= '0;
            i_done    <= 1'b0;
            i_rdata   <= '0;
            d_done    <= 1'b0;
            d_rdata   <= '0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            busy      <= 1'b0;
            owner_d   <= 1'b0;
        end else begin
            mem_en <= 1'b0;
            mem_we <= 1'b0;
            i_done <= 1'b0;
            d_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_arb) begin
                        r_owner <= w_win;
                        owner_d <= (w_win == OWN_D);
                        mem_en  <= 1'b1;
                        busy    <= 1'b1;
                        r_state <= ISSUE;
                        if (w_win == OWN_D) begin
                            mem_we    <= d_we;
                            mem_addr  <= d_addr;
                            mem_wdata <= d_wdata;
                        end else begin
                            mem_addr  <= i_addr;
                        end
                    end
                end
                ISSUE: begin
                    if (mem_we) begin
                        d_done  <= (r_owner == OWN_D);
                        i_done  <= (r_owner == OWN_I);
                        r_state <= DONE;
                    end else begin
                        r_lat   <= LW'(MEM_LAT);
                        r_state <= WAIT;
                    end
                end
                WAIT: begin
                    r_lat <= r_lat - LW'(1);
                    if (r_lat == LW'(1)) begin
                        if (r_owner == OWN_D) begin
                            d_rdata <= mem_rdata;
                            d_done  <= 1'b1;
                        end else begin
                            i_rdata <= mem_rdata;
                            i_done  <= 1'b1;
                        end
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    busy    <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter with a behavioural RAM of read latency LAT.
// Build with MEMARB_RR_EN defined to expect round-robin tie order.
module tb_mem_port_arbiter;

    localparam int AW  = 16;
    localparam int DW  = 16;
    localparam int LAT = 2;
    localparam int LIM = 3;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          i_req = 1'b0;
    logic [AW-1:0] i_addr = '0;
    logic          i_done;
    logic [DW-1:0] i_rdata;
    logic          d_req = 1'b0;
    logic          d_we = 1'b0;
    logic [AW-1:0] d_addr = '0;
    logic [DW-1:0] d_wdata = '0;
    logic          d_done;
    logic [DW-1:0] d_rdata;
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          busy;
    logic          owner_d;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .AW(AW), .DW(DW), .MEM_LAT(LAT), .STARVE_LIMIT(LIM)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .i_req(i_req), .i_addr(i_addr), .i_done(i_done), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_done(d_done), .d_rdata(d_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .busy(busy), .owner_d(owner_d)
    );

    // RAM: data for an access issued in cycle C is on mem_rdata in cycle C+LAT.
    logic [DW-1:0] mem [0:4095];
    logic [DW-1:0] rd_pipe [LAT];
    always @(posedge clk) begin
        if (mem_en && mem_we) mem[mem_addr[11:0]] <= mem_wdata;
        rd_pipe[0] <= mem[mem_addr[11:0]];
        for (int k = 1; k < LAT; k++) rd_pipe[k] <= rd_pipe[k-1];
    end
    assign mem_rdata = rd_pipe[LAT-1];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad = 0;

    typedef struct {
        logic [AW-1:0] addr;
        logic          we;
        logic [DW-1:0] wdata;
        int            at;
    } iss_t;

    typedef struct {
        logic          side_d;
        logic          rd;
        logic [DW-1:0] data;
        int            at;
    } dn_t;

    iss_t iq[$];
    dn_t  dq[$];
    logic [DW-1:0] exp_ir = '0;
    logic [DW-1:0] exp_dr = '0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic push_iss(input logic [AW-1:0] a, input logic we, input logic [DW-1:0] wd, input int at);
        iss_t e;
        e.addr = a; e.we = we; e.wdata = wd; e.at = at;
        iq.push_back(e);
    endtask

    task automatic push_dn(input logic sd, input logic rd, input logic [DW-1:0] d, input int at);
        dn_t e;
        e.side_d = sd; e.rd = rd; e.data = d; e.at = at;
        dq.push_back(e);
    endtask

    // Monitor: pops expectations whenever the DUT strobes mem_en or a done.
    always @(negedge clk) begin : monitor
        iss_t ie;
        dn_t  de;
        if (reset_n) begin
            if (mem_en) begin
                if (iq.size() == 0) begin
                    chk("unexpected_issue", 32'(mem_addr), 32'hFFFF_FFFF);
                end else begin
                    ie = iq.pop_front();
                    chk("issue_cycle", 32'(cyc), 32'(ie.at));
                    chk("issue_addr", 32'(mem_addr), 32'(ie.addr));
                    chk("issue_we", 32'(mem_we), 32'(ie.we));
                    if (ie.we) chk("issue_wdata", 32'(mem_wdata), 32'(ie.wdata));
                end
            end
            if (i_done || d_done) begin
                chk("done_exclusive", 32'(i_done & d_done), 32'd0);
                if (dq.size() == 0) begin
                    chk("unexpected_done", {30'd0, d_done, i_done}, 32'd0);
                end else begin
                    de = dq.pop_front();
                    chk("done_cycle", 32'(cyc), 32'(de.at));
                    chk("done_side", 32'(d_done), 32'(de.side_d));
                    if (de.side_d && de.rd) exp_dr = de.data;
                    if (!de.side_d) exp_ir = de.data;
                    chk("d_rdata", 32'(d_rdata), 32'(exp_dr));
                    chk("i_rdata", 32'(i_rdata), 32'(exp_ir));
                end
            end
        end
    end

    // Returns at #1 into the IDLE cycle following the done pulse.
    task automatic wait_done(input logic side_d, input int budget);
        logic seen;
        seen = 1'b0;
        for (int t = 0; t < budget && !seen; t++) begin
            @(negedge clk);
            seen = side_d ? d_done : i_done;
        end
        chk("done_timeout", 32'(seen), 32'd1);
        if (side_d) d_req = 1'b0;
        else        i_req = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic fetch(input logic [AW-1:0] a, input logic [DW-1:0] d);
        int n;
        n = cyc;
        i_addr = a;
        i_req  = 1'b1;
        push_iss(a, 1'b0, '0, n + 1);
        push_dn(1'b0, 1'b1, d, n + 2 + LAT);
        wait_done(1'b0, 20);
    endtask

    task automatic dacc(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] wd, input logic [DW-1:0] d);
        int n;
        n = cyc;
        d_we    = we;
        d_addr  = a;
        d_wdata = wd;
        d_req   = 1'b1;
        push_iss(a, we, wd, n + 1);
        push_dn(1'b1, !we, d, we ? n + 2 : n + 2 + LAT);
        wait_done(1'b1, 20);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_owner_d"}, 32'(owner_d), 32'd0);
        chk({tag, "_mem_en"}, 32'(mem_en), 32'd0);
        chk({tag, "_mem_we"}, 32'(mem_we), 32'd0);
        chk({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
        chk({tag, "_mem_wdata"}, 32'(mem_wdata), 32'd0);
        chk({tag, "_done"}, {30'd0, i_done, d_done}, 32'd0);
        chk({tag, "_i_rdata"}, 32'(i_rdata), 32'd0);
        chk({tag, "_d_rdata"}, 32'(d_rdata), 32'd0);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin : stim
        int n0;
        logic sd;
        mem[12'h010] = 16'hA5C3;
        mem[12'h000] = 16'h0AA0;
        mem[12'h001] = 16'h0BB1;
        mem[12'h200] = 16'h0000;

        repeat (2) @(posedge clk);
        #1;
        chk_all_zero("reset");
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // Fetch-only read.
        fetch(16'h0010, 16'hA5C3);

        // Store then load back.
        dacc(1'b1, 16'h0200, 16'h1234, 16'h0000);
        dacc(1'b0, 16'h0200, 16'h0000, 16'h1234);

        // Reset in the first WAIT cycle of a load: no done, everything clears.
        n0 = cyc;
        d_we = 1'b0; d_addr = 16'h0010; d_req = 1'b1;
        push_iss(16'h0010, 1'b0, '0, n0 + 1);
        repeat (2) @(posedge clk);
        #2;
        reset_n = 1'b0;
        d_req = 1'b0;
        exp_ir = '0;
        exp_dr = '0;
        #1;
        chk_all_zero("async_rst");
        @(posedge clk);
        #3;
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst_busy", 32'(busy), 32'd0);
        fetch(16'h0010, 16'hA5C3);

        // Back-to-back fetches, second raised in the IDLE cycle after i_done.
        fetch(16'h0000, 16'h0AA0);
        fetch(16'h0001, 16'h0BB1);

        // Both sides held high: grant order from a fresh reset.
        reset_n = 1'b0;
        exp_ir = '0;
        exp_dr = '0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        n0 = cyc;
        i_addr = 16'h0010;
        d_addr = 16'h0200;
        d_we   = 1'b0;
        i_req  = 1'b1;
        d_req  = 1'b1;
        for (int k = 0; k < 8; k++) begin
`ifdef MEMARB_RR_EN
            sd = (k % 2) == 1;
`else
            sd = (k % 4) != 3;
`endif
            push_iss(sd ? 16'h0200 : 16'h0010, 1'b0, '0, n0 + 5 * k + 1);
            push_dn(sd, 1'b1, sd ? 16'h1234 : 16'hA5C3, n0 + 5 * k + 2 + LAT);
        end
        repeat (40) @(posedge clk);
        #1;
        i_req = 1'b0;
        d_req = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        chk("idle_busy", 32'(busy), 32'd0);
        chk("issue_queue_empty", 32'(iq.size()), 32'd0);
        chk("done_queue_empty", 32'(dq.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
